full_adder_checker: RTL and testbench
=====================================

FULL_ADDER_CHECKER -- requirements
Module: full_adder_checker

Interface
REQ-001 The module SHALL have parameter CNT_W, default 8, the width of the pass and fail counters.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port start, input, 1 bit: a one-cycle pulse that clears results and arms checking.
REQ-005 The module SHALL have port in_valid, input, 1 bit: the observed vector on A/B/C/SUM/COUT is valid this cycle.
REQ-006 The module SHALL have ports A, B, C, input, 1 bit each: the full-adder operand inputs as driven to the DUT.
REQ-007 The module SHALL have ports SUM, COUT, input, 1 bit each: the DUT full-adder outputs.
REQ-008 The module SHALL have port in_ready, output, 1 bit: the checker accepts a vector this cycle.
REQ-009 The module SHALL have ports pass_cnt and fail_cnt, output, CNT_W bits each: the counts of matching and mismatching vectors.
REQ-010 The module SHALL have port cov, output, 8 bits: the coverage bitmap, with bit {A,B,C} set once that combination is accepted.
REQ-011 The module SHALL have port done, output, 1 bit: all 8 combinations have been covered.
REQ-012 The module SHALL have port error, output, 1 bit: sticky; at least one mismatch has occurred since the last start.
REQ-013 The module SHALL have port first_fail, output, 5 bits: {A,B,C,SUM,COUT} of the first mismatching vector.

Function
REQ-014 The checker SHALL implement states IDLE, RUN, DONE and HALT.
REQ-015 in_ready SHALL be 1 only in RUN.
REQ-016 A vector SHALL be accepted when in_valid=1, in_ready=1 and start=0.
REQ-017 For an accepted vector, expected sum SHALL be A^B^C and expected carry SHALL be (A&B)|(A&C)|(B&C); the vector matches only if both SUM and COUT equal the expected values.
REQ-018 An accepted vector SHALL update pass_cnt or fail_cnt, cov, error and first_fail on the next rising edge (1-cycle latency).
REQ-019 pass_cnt and fail_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-020 first_fail SHALL be captured only on the first mismatch after start; later mismatches SHALL NOT change it.
REQ-021 A repeated combination SHALL be counted again but SHALL NOT alter cov.
REQ-022 The state SHALL go RUN->DONE on the edge at which cov becomes 8'hFF; the completing vector SHALL be counted; done SHALL be 1 in DONE and 0 elsewhere.
REQ-023 start in any state SHALL, on the next edge, zero the counters, cov, error and first_fail and enter RUN.
REQ-024 When start and in_valid are both high in the same cycle, start SHALL win and the vector SHALL be discarded.
REQ-025 Vectors presented in IDLE, DONE or HALT SHALL be ignored, with no state change.

Reset
REQ-026 While rst=1 at a clock edge, the state SHALL become IDLE and pass_cnt, fail_cnt, cov, first_fail, error, done and in_ready SHALL all be 0.
REQ-027 rst SHALL override start and in_valid, including mid-RUN; partial results SHALL be discarded.

Configuration
REQ-028 When macro FA_CHK_STOP_ON_ERR_EN is defined, the first mismatch SHALL move the state RUN->HALT on the same edge the mismatch is recorded; HALT SHALL be left only by start or rst.
REQ-029 When FA_CHK_STOP_ON_ERR_EN is undefined, the HALT state SHALL be unreachable, and mismatches SHALL be recorded while checking continues in RUN.

Verification
REQ-030 The bench SHALL cover this scenario: rst, then start, then the 8 vectors 000..111 with correct SUM/COUT, one per cycle -> pass_cnt=8, fail_cnt=0, cov=8'hFF, done=1 one cycle after the 8th, in_ready=0.
REQ-031 The bench SHALL cover this scenario: start, then vector A=0,B=1,C=1 with SUM=1,COUT=1 -> error=1, fail_cnt=1, first_fail=5'b01111.
REQ-032 The bench SHALL cover this scenario: start and in_valid asserted in the same cycle with a bad vector -> counters stay 0, error=0.
REQ-033 The bench SHALL cover this scenario: with CNT_W=2, 5 correct copies of vector 000 -> pass_cnt=3 (saturated), cov=8'h01, done=0.
REQ-034 The bench SHALL cover this scenario: rst asserted after 4 vectors in RUN -> all outputs 0 and IDLE; a following vector is ignored.
REQ-035 The bench SHALL cover this scenario: with FA_CHK_STOP_ON_ERR_EN defined, a mismatch followed by 3 good vectors -> fail_cnt=1, pass_cnt unchanged, in_ready=0; then start -> RUN with cleared results.

Source files
------------

// File: rtl/full_adder_checker.sv
// Full-adder checker: scores observed A/B/C/SUM/COUT vectors against the
// reference full-adder equations, with pass/fail counters, coverage and
// first-failure capture.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             one-cycle pulse: clear results and enter RUN
//   in_valid          A/B/C/SUM/COUT hold a vector this cycle
//   A, B, C           operands driven to the adder under test
//   SUM, COUT         outputs of the adder under test
//   in_ready          high only in RUN
//   pass_cnt          saturating count of matching vectors
//   fail_cnt          saturating count of mismatching vectors
//   cov               bit {A,B,C} set once that combination is accepted
//   done              all 8 combinations covered
//   error             sticky mismatch flag since last start
//   first_fail        {A,B,C,SUM,COUT} of the first mismatch
//
// Build option: define FA_CHK_STOP_ON_ERR_EN to halt checking on the
// first mismatch (HALT state, left only by start or rst).
module full_adder_checker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  input  logic             SUM,
  input  logic             COUT,
  output logic             in_ready,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [7:0]       cov,
  output logic             done,
  output logic             error,
  output logic [4:0]       first_fail
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    HALT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_pass;
  logic [CNT_W-1:0] r_fail;
  logic [7:0]       r_cov;
  logic             r_error;
  logic [4:0]       r_first;

  logic       w_acc;
  logic       w_exp_s;
  logic       w_exp_c;
  logic       w_match;
  logic [2:0] w_idx;
  logic [7:0] w_cov_nxt;

  assign w_idx     = {A, B, C};
  assign w_exp_s   = A ^ B ^ C;
  assign w_exp_c   = (A & B) | (A & C) | (B & C);
  assign w_match   = (SUM == w_exp_s) && (COUT == w_exp_c);
  // start wins over a same-cycle vector
  assign w_acc     = in_valid && (r_state == RUN) && !start;
  assign w_cov_nxt = r_cov | (8'd1 << w_idx);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (start) begin
      w_state_nxt = RUN;
    end else if (w_acc) begin
`ifdef FA_CHK_STOP_ON_ERR_EN
      // a first mismatch halts even if it also completes coverage
      if (!w_match && !r_error)
        w_state_nxt = HALT;
      else if (w_cov_nxt == 8'hFF)
        w_state_nxt = DONE;
`else
      if (w_cov_nxt == 8'hFF)
        w_state_nxt = DONE;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      r_pass  <= '0;
      r_fail  <= '0;
      r_cov   <= '0;
      r_error <= 1'b0;
      r_first <= '0;
    end else if (w_acc) begin
      r_cov <= w_cov_nxt;
      if (w_match) begin
        if (r_pass != CNT_MAX) r_pass <= r_pass + 1'b1;
      end else begin
        if (r_fail != CNT_MAX) r_fail <= r_fail + 1'b1;
        if (!r_error) r_first <= {A, B, C, SUM, COUT};
        r_error <= 1'b1;
      end
    end
  end

  assign in_ready   = (r_state == RUN);
  assign done       = (r_state == DONE);
  assign pass_cnt   = r_pass;
  assign fail_cnt   = r_fail;
  assign cov        = r_cov;
  assign error      = r_error;
  assign first_fail = r_first;

endmodule

// File: tb/tb_full_adder_checker.sv
// Directed bench for full_adder_checker: CNT_W=8 and CNT_W=2 instances
// share stimulus; expectations are hand-computed constants.
module tb_full_adder_checker;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic A = 1'b0, B = 1'b0, C = 1'b0;
  logic SUM = 1'b0, COUT = 1'b0;

  logic       rdy8, done8, err8;
  logic [7:0] pass8, fail8, cov8;
  logic [4:0] ff8;
  logic       rdy2, done2, err2;
  logic [1:0] pass2, fail2;
  logic [7:0] cov2;
  logic [4:0] ff2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  full_adder_checker #(.CNT_W(8)) u8 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .A(A), .B(B), .C(C), .SUM(SUM), .COUT(COUT),
    .in_ready(rdy8), .pass_cnt(pass8), .fail_cnt(fail8),
    .cov(cov8), .done(done8), .error(err8), .first_fail(ff8)
  );

  full_adder_checker #(.CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .A(A), .B(B), .C(C), .SUM(SUM), .COUT(COUT),
    .in_ready(rdy2), .pass_cnt(pass2), .fail_cnt(fail2),
    .cov(cov2), .done(done2), .error(err2), .first_fail(ff2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // apply inputs at negedge, sample 1 time unit after the next posedge
  task automatic step(input logic st, input logic v, input logic a,
                      input logic b, input logic c, input logic s,
                      input logic co);
    @(negedge clk);
    start = st; in_valid = v;
    A = a; B = b; C = c; SUM = s; COUT = co;
    @(posedge clk);
    #1;
    start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic good(input logic [2:0] v);
    step(0, 1, v[2], v[1], v[0], ^v,
         (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]));
  endtask

  initial begin
    // reset
    rst = 1'b1;
    idle();
    idle();
    rst = 1'b0;
    chk("rst_ready", rdy8, 0);
    chk("rst_pass", pass8, 0);
    chk("rst_fail", fail8, 0);
    chk("rst_cov", cov8, 0);
    chk("rst_done", done8, 0);
    chk("rst_err", err8, 0);
    chk("rst_ff", ff8, 0);
    good(3'b000);
    chk("idle_ignore", pass8, 0);

    // all 8 correct vectors
    step(1, 0, 0, 0, 0, 0, 0);
    chk("start_ready", rdy8, 1);
    for (int i = 0; i < 7; i++) good(i[2:0]);
    chk("seven_cov", cov8, 8'h7F);
    chk("seven_done", done8, 0);
    good(3'b111);
    chk("all_pass", pass8, 8);
    chk("all_fail", fail8, 0);
    chk("all_cov", cov8, 8'hFF);
    chk("all_done", done8, 1);
    chk("all_ready", rdy8, 0);
    good(3'b010);
    chk("done_ignore", pass8, 8);

    // single mismatch A=0,B=1,C=1 SUM=1 COUT=1
    step(1, 0, 0, 0, 0, 0, 0);
    chk("restart_pass", pass8, 0);
    chk("restart_done", done8, 0);
    step(0, 1, 0, 1, 1, 1, 1);
    chk("mm_err", err8, 1);
    chk("mm_fail", fail8, 1);
    chk("mm_ff", ff8, 5'b01111);
    chk("mm_cov", cov8, 8'h08);
    step(0, 1, 1, 0, 0, 0, 0);
`ifdef FA_CHK_STOP_ON_ERR_EN
    chk("mm2_fail", fail8, 1);
`else
    chk("mm2_fail", fail8, 2);
`endif
    chk("mm2_ff", ff8, 5'b01111);

    // start and bad vector in same cycle
    step(1, 1, 0, 1, 1, 1, 1);
    chk("sv_fail", fail8, 0);
    chk("sv_pass", pass8, 0);
    chk("sv_err", err8, 0);
    chk("sv_cov", cov8, 0);
    chk("sv_ready", rdy8, 1);

    // saturation: 5 copies of 000
    for (int i = 0; i < 5; i++) good(3'b000);
    chk("sat2_pass", pass2, 3);
    chk("sat2_cov", cov2, 8'h01);
    chk("sat2_done", done2, 0);
    chk("sat8_pass", pass8, 5);

    // reset mid-run after 4 vectors
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) good(i[2:0]);
    chk("pre_rst_pass", pass8, 4);
    rst = 1'b1;
    step(1, 1, 1, 1, 1, 1, 1);
    rst = 1'b0;
    chk("mrst_ready", rdy8, 0);
    chk("mrst_pass", pass8, 0);
    chk("mrst_cov", cov8, 0);
    chk("mrst_err", err8, 0);
    chk("mrst_done", done8, 0);
    good(3'b101);
    chk("mrst_ignore", pass8, 0);
    chk("mrst_ignore_cov", cov8, 0);

    // mismatch followed by 3 good vectors
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 1, 1);
    good(3'b000);
    good(3'b001);
    good(3'b010);
    chk("stop_fail", fail8, 1);
    chk("stop_ff", ff8, 5'b11011);
`ifdef FA_CHK_STOP_ON_ERR_EN
    chk("stop_pass", pass8, 0);
    chk("stop_ready", rdy8, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("halt_restart_ready", rdy8, 1);
    chk("halt_restart_fail", fail8, 0);
    chk("halt_restart_err", err8, 0);
`else
    chk("stop_pass", pass8, 3);
    chk("stop_ready", rdy8, 1);
    chk("stop_cov", cov8, 8'h47);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
